// File: rtl/riscv_result_checker_pkg.sv
// rtl/riscv_result_checker_pkg.sv - shared state encoding and default sizes for the result checker
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_t;

  localparam int          DEF_NUM_TEST       = 26;
  localparam int          DEF_IDX_W          = 5;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd100000;

endpackage

// File: rtl/riscv_result_checker_if.sv
// rtl/riscv_result_checker_if.sv - core observation, table load and status bundle for the checker
import riscv_chk_pkg::*;

interface riscv_result_checker_if #(
  parameter int IDX_W = DEF_IDX_W
);
  logic [31:0]      NUM_INST;
  logic [31:0]      OUTPUT_PORT;
  logic             HALT;
  logic             TBL_WE;
  logic [IDX_W-1:0] TBL_ADDR;
  logic [31:0]      TBL_NUM;
  logic [31:0]      TBL_ANS;
  logic             START;
  logic [31:0]      CYCLE;
  logic [IDX_W:0]   PASS_CNT;
  logic             FAIL;
  logic [IDX_W-1:0] FAIL_IDX;
  logic [31:0]      FAIL_GOT;
  logic             TIMEOUT;
  logic             DONE;
  logic             SUCCESS;

  modport master (
    output NUM_INST, OUTPUT_PORT, HALT, TBL_WE, TBL_ADDR, TBL_NUM, TBL_ANS, START,
    input  CYCLE, PASS_CNT, FAIL, FAIL_IDX, FAIL_GOT, TIMEOUT, DONE, SUCCESS
  );

  modport slave (
    input  NUM_INST, OUTPUT_PORT, HALT, TBL_WE, TBL_ADDR, TBL_NUM, TBL_ANS, START,
    output CYCLE, PASS_CNT, FAIL, FAIL_IDX, FAIL_GOT, TIMEOUT, DONE, SUCCESS
  );
endinterface

// File: rtl/riscv_result_checker_table.sv
// rtl/riscv_result_checker_table.sv - expected {num, ans} store, synchronous write, combinational read
import riscv_chk_pkg::*;

module chk_table #(
  parameter int NUM_TEST = DEF_NUM_TEST,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wnum,
  input  logic [31:0]      wans,
  input  logic [IDX_W:0]   raddr,
  output logic [31:0]      rnum,
  output logic [31:0]      rans
);
  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_TEST);

  logic [63:0] mem [NUM_TEST];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH))
      mem[waddr] <= {wnum, wans};
  end

  // raddr may sit at DEPTH once every entry has been consumed
  always_comb begin
    {rnum, rans} = 64'd0;
    if (raddr < DEPTH)
      {rnum, rans} = mem[raddr[IDX_W-1:0]];
  end
endmodule

// File: rtl/riscv_result_checker.sv
// rtl/riscv_result_checker.sv - in-order retired-result checker FSM; watchdog under CHECKER_TIMEOUT_EN
import riscv_chk_pkg::*;

module riscv_result_checker #(
  parameter int          NUM_TEST       = DEF_NUM_TEST,
  parameter int          IDX_W          = DEF_IDX_W,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   CLK,
  input logic                   RSTn,
  riscv_result_checker_if.slave bus
);
  localparam logic [IDX_W:0] LAST_PTR = (IDX_W+1)'(NUM_TEST);
`ifdef CHECKER_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  chk_state_t       state;
  logic [IDX_W:0]   ptr;
  logic [IDX_W:0]   pass_cnt;
  logic [31:0]      cycle;
  logic [31:0]      fail_got;
  logic [IDX_W-1:0] fail_idx;
  logic             fail, timeout, done, success;
  logic [31:0]      exp_num, exp_ans;
  logic             check_hit, ans_ok, wdog_hit;

  chk_table #(.NUM_TEST(NUM_TEST), .IDX_W(IDX_W)) u_table (
    .clk   (CLK),
    .we    (bus.TBL_WE && RSTn && (state == ST_IDLE)),
    .waddr (bus.TBL_ADDR),
    .wnum  (bus.TBL_NUM),
    .wans  (bus.TBL_ANS),
    .raddr (ptr),
    .rnum  (exp_num),
    .rans  (exp_ans)
  );

  assign check_hit = (state == ST_RUN) && (ptr < LAST_PTR) && (bus.NUM_INST == exp_num);
  assign ans_ok    = (bus.OUTPUT_PORT == exp_ans);
  assign wdog_hit  = WDOG_EN && (cycle == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      pass_cnt <= '0;
      cycle    <= 32'd0;
      fail     <= 1'b0;
      fail_idx <= '0;
      fail_got <= 32'd0;
      timeout  <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            state    <= ST_RUN;
            ptr      <= '0;
            pass_cnt <= '0;
            cycle    <= 32'd0;
          end
        end
        ST_RUN: begin
          if (cycle != 32'hFFFF_FFFF)
            cycle <= cycle + 32'd1;
          // mismatch outranks HALT and the watchdog; a same-cycle match still counts before HALT
          if (check_hit && !ans_ok) begin
            state    <= ST_FAIL;
            fail     <= 1'b1;
            done     <= 1'b1;
            fail_idx <= ptr[IDX_W-1:0];
            fail_got <= bus.OUTPUT_PORT;
          end else begin
            if (check_hit) begin
              ptr      <= ptr + 1'b1;
              pass_cnt <= pass_cnt + 1'b1;
            end
            if (bus.HALT) begin
              state   <= ST_PASS;
              success <= 1'b1;
              done    <= 1'b1;
            end else if (wdog_hit) begin
              state    <= ST_FAIL;
              fail     <= 1'b1;
              timeout  <= 1'b1;
              done     <= 1'b1;
              fail_idx <= ptr[IDX_W-1:0];
              fail_got <= bus.OUTPUT_PORT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.CYCLE    = cycle;
  assign bus.PASS_CNT = pass_cnt;
  assign bus.FAIL     = fail;
  assign bus.FAIL_IDX = fail_idx;
  assign bus.FAIL_GOT = fail_got;
  assign bus.TIMEOUT  = timeout;
  assign bus.DONE     = done;
  assign bus.SUCCESS  = success;
endmodule

// File: tb/tb_riscv_result_checker.sv
// tb/tb_riscv_result_checker.sv - directed scoreboard bench for riscv_result_checker
module tb_riscv_result_checker;
  logic CLK;
  logic RSTn;
  logic obs;
  int   n_cmp;
  int   n_bad;

  riscv_result_checker_if #(.IDX_W(5)) bus ();

  riscv_result_checker #(.NUM_TEST(26), .IDX_W(5), .TIMEOUT_CYCLES(32'd50)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [5:0]  pass_cnt;
    logic        fail;
    logic [4:0]  fail_idx;
    logic [31:0] fail_got;
    logic        timeout;
    logic        done;
    logic        success;
    bit          chk_cycle;
    logic [31:0] cycle;
  } exp_t;

  exp_t sb[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pops one expectation whenever the stimulus side raises obs
  always @(negedge CLK) begin
    if (obs) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow got 0 entries expected 1");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "pass_cnt", 32'(bus.PASS_CNT), 32'(e.pass_cnt));
        cmp(e.name, "fail",     32'(bus.FAIL),     32'(e.fail));
        cmp(e.name, "fail_idx", 32'(bus.FAIL_IDX), 32'(e.fail_idx));
        cmp(e.name, "fail_got", bus.FAIL_GOT,      e.fail_got);
        cmp(e.name, "timeout",  32'(bus.TIMEOUT),  32'(e.timeout));
        cmp(e.name, "done",     32'(bus.DONE),     32'(e.done));
        cmp(e.name, "success",  32'(bus.SUCCESS),  32'(e.success));
        if (e.chk_cycle)
          cmp(e.name, "cycle", bus.CYCLE, e.cycle);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_st(string nm, logic [5:0] pc, logic f, logic [4:0] fi, logic [31:0] fg,
                           logic to, logic d, logic s, bit cc, logic [31:0] cyc);
    exp_t e;
    e.name = nm; e.pass_cnt = pc; e.fail = f; e.fail_idx = fi; e.fail_got = fg;
    e.timeout = to; e.done = d; e.success = s; e.chk_cycle = cc; e.cycle = cyc;
    sb.push_back(e);
    obs = 1'b1;
    @(negedge CLK);
    #1;
    obs = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    bus.NUM_INST = 32'd0; bus.OUTPUT_PORT = 32'd0; bus.HALT = 1'b0;
    bus.START = 1'b0; bus.TBL_WE = 1'b0;
  endtask

  task automatic load(logic [4:0] a, logic [31:0] num, logic [31:0] ans);
    bus.TBL_WE = 1'b1; bus.TBL_ADDR = a; bus.TBL_NUM = num; bus.TBL_ANS = ans;
    tick();
    bus.TBL_WE = 1'b0;
  endtask

  task automatic start_run();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic step(logic [31:0] num, logic [31:0] outp, logic halt);
    bus.NUM_INST = num; bus.OUTPUT_PORT = outp; bus.HALT = halt;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; obs = 1'b0;
    RSTn = 1'b0;
    bus.NUM_INST = 32'd0; bus.OUTPUT_PORT = 32'd0; bus.HALT = 1'b0; bus.START = 1'b0;
    bus.TBL_WE = 1'b0; bus.TBL_ADDR = 5'd0; bus.TBL_NUM = 32'd0; bus.TBL_ANS = 32'd0;
    tick(); tick();
    RSTn = 1'b1;
    expect_st("reset", 6'd0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd0);

    for (int i = 0; i < 26; i++) load(5'(i), 32'hFFFF_FFFF, 32'd0);
    load(5'd0, 32'd1, 32'd0);
    load(5'd1, 32'd2, 32'd0);
    load(5'd2, 32'd3, 32'd5);
    load(5'd31, 32'd1, 32'd0);

    // all three entries pass, then HALT
    start_run();
    expect_st("run_start", 6'd0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd0);
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd5, 0);
    expect_st("three_pass", 6'd3, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd3);
    step(32'd3, 32'd5, 1);
    expect_st("halt_pass", 6'd3, 0, 5'd0, 32'd0, 0, 1, 1, 1, 32'd4);
    tick();
    expect_st("pass_terminal", 6'd3, 0, 5'd0, 32'd0, 0, 1, 1, 1, 32'd4);

    // mismatch on entry 2
    do_reset();
    start_run();
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd7, 0);
    expect_st("mismatch", 6'd2, 1, 5'd2, 32'd7, 0, 1, 0, 1, 32'd3);
    step(32'd3, 32'd5, 1);
    expect_st("fail_terminal", 6'd2, 1, 5'd2, 32'd7, 0, 1, 0, 1, 32'd3);

    // HALT together with a matching final entry
    do_reset();
    start_run();
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd5, 1);
    expect_st("halt_with_match", 6'd3, 0, 5'd0, 32'd0, 0, 1, 1, 1, 32'd3);

    // HALT together with a mismatch
    do_reset();
    start_run();
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd6, 1);
    expect_st("halt_with_mismatch", 6'd2, 1, 5'd2, 32'd6, 0, 1, 0, 1, 32'd3);

    // reset mid-run; START and TBL_WE during reset must be ignored
    do_reset();
    start_run();
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    expect_st("mid_run", 6'd2, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd2);
    RSTn = 1'b0; bus.START = 1'b1;
    bus.TBL_WE = 1'b1; bus.TBL_ADDR = 5'd0; bus.TBL_NUM = 32'd1; bus.TBL_ANS = 32'd9;
    tick();
    RSTn = 1'b1; bus.START = 1'b0; bus.TBL_WE = 1'b0; bus.NUM_INST = 32'd0;
    expect_st("reset_mid_run", 6'd0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd0);
    step(32'd1, 32'd0, 0);
    step(32'd1, 32'd0, 0);
    expect_st("stays_idle", 6'd0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd0);
    bus.NUM_INST = 32'd0;
    start_run();
    step(32'd1, 32'd0, 0);
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd5, 1);
    expect_st("rerun_after_reset", 6'd3, 0, 5'd0, 32'd0, 0, 1, 1, 1, 32'd3);

    // table writes during RUN are ignored
    do_reset();
    start_run();
    bus.TBL_WE = 1'b1; bus.TBL_ADDR = 5'd2; bus.TBL_NUM = 32'd3; bus.TBL_ANS = 32'd7;
    step(32'd1, 32'd0, 0);
    bus.TBL_WE = 1'b0;
    step(32'd2, 32'd0, 0);
    step(32'd3, 32'd5, 1);
    expect_st("we_in_run_ignored", 6'd3, 0, 5'd0, 32'd0, 0, 1, 1, 1, 32'd3);

    // watchdog behaviour with no HALT
    do_reset();
    start_run();
    for (int i = 0; i < 60; i++) step(32'd0, 32'h1234, 0);
`ifdef CHECKER_TIMEOUT_EN
    expect_st("watchdog", 6'd0, 1, 5'd0, 32'h1234, 1, 1, 0, 1, 32'd50);
`else
    expect_st("no_watchdog", 6'd0, 0, 5'd0, 32'd0, 0, 0, 0, 1, 32'd60);
`endif

    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
